// File: rtl/scariv_pred_update_sched_if.sv
// Request/update bundle for the branch-predictor update scheduler.
// master = scheduler side, slave = requesters plus predictor tables.
interface scariv_pred_update_sched_if #(
  parameter int REQ_NUM     = 2,
  parameter int QUEUE_DEPTH = 4,
  parameter int VADDR_W     = 39
);
  logic [REQ_NUM-1:0]              i_req_valid;
  logic [REQ_NUM-1:0]              o_req_ready;
  logic [REQ_NUM-1:0][VADDR_W-1:0] i_req_pc_vaddr;
  logic [REQ_NUM-1:0][VADDR_W-1:0] i_req_target_vaddr;
  logic [REQ_NUM-1:0]              i_req_is_cond;
  logic [REQ_NUM-1:0]              i_req_is_call;
  logic [REQ_NUM-1:0]              i_req_is_ret;
  logic [REQ_NUM-1:0]              i_req_is_rvc;
  logic [REQ_NUM-1:0]              i_req_taken;
  logic [REQ_NUM-1:0]              i_req_mispredict;
  logic [REQ_NUM-1:0]              i_req_btb_hit;
  logic [REQ_NUM-1:0][1:0]         i_req_bim_value;
  logic                            i_upd_stall;

  logic                            o_btb_upd_valid;
  logic                            o_btb_upd_is_cond;
  logic                            o_btb_upd_is_call;
  logic                            o_btb_upd_is_ret;
  logic                            o_btb_upd_is_rvc;
  logic                            o_btb_upd_taken;
  logic                            o_btb_upd_mispredict;
  logic [VADDR_W-1:0]              o_btb_upd_pc_vaddr;
  logic [VADDR_W-1:0]              o_btb_upd_target_vaddr;

  logic                            o_bim_upd_valid;
  logic [VADDR_W-1:0]              o_bim_upd_pc_vaddr;
  logic                            o_bim_upd_hit;
  logic                            o_bim_upd_taken;
  logic [1:0]                      o_bim_upd_bim_value;
  logic                            o_bim_upd_is_rvc;

  logic [$clog2(QUEUE_DEPTH):0]    o_queue_count;
  logic                            o_queue_full;

  modport master (
    input  i_req_valid, i_req_pc_vaddr, i_req_target_vaddr, i_req_is_cond, i_req_is_call,
           i_req_is_ret, i_req_is_rvc, i_req_taken, i_req_mispredict, i_req_btb_hit,
           i_req_bim_value, i_upd_stall,
    output o_req_ready,
           o_btb_upd_valid, o_btb_upd_is_cond, o_btb_upd_is_call, o_btb_upd_is_ret,
           o_btb_upd_is_rvc, o_btb_upd_taken, o_btb_upd_mispredict,
           o_btb_upd_pc_vaddr, o_btb_upd_target_vaddr,
           o_bim_upd_valid, o_bim_upd_pc_vaddr, o_bim_upd_hit, o_bim_upd_taken,
           o_bim_upd_bim_value, o_bim_upd_is_rvc,
           o_queue_count, o_queue_full
  );

  modport slave (
    output i_req_valid, i_req_pc_vaddr, i_req_target_vaddr, i_req_is_cond, i_req_is_call,
           i_req_is_ret, i_req_is_rvc, i_req_taken, i_req_mispredict, i_req_btb_hit,
           i_req_bim_value, i_upd_stall,
    input  o_req_ready,
           o_btb_upd_valid, o_btb_upd_is_cond, o_btb_upd_is_call, o_btb_upd_is_ret,
           o_btb_upd_is_rvc, o_btb_upd_taken, o_btb_upd_mispredict,
           o_btb_upd_pc_vaddr, o_btb_upd_target_vaddr,
           o_bim_upd_valid, o_bim_upd_pc_vaddr, o_bim_upd_hit, o_bim_upd_taken,
           o_bim_upd_bim_value, o_bim_upd_is_rvc,
           o_queue_count, o_queue_full
  );
endinterface

// File: rtl/scariv_pred_update_sched.sv
// Round-robin collector of resolved-branch updates feeding one BTB/BIM write port
// through a small FIFO; one accept and one issue per cycle, no bypass paths.
module scariv_pred_update_sched #(
  parameter int REQ_NUM     = 2,
  parameter int QUEUE_DEPTH = 4,
  parameter int VADDR_W     = 39
) (
  input logic                        i_clk,
  input logic                        i_reset_n,
  scariv_pred_update_sched_if.master bus
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RR_W  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  typedef struct packed {
    logic [VADDR_W-1:0] pc_vaddr;
    logic [VADDR_W-1:0] target_vaddr;
    logic               is_cond;
    logic               is_call;
    logic               is_ret;
    logic               is_rvc;
    logic               taken;
    logic               mispredict;
    logic               btb_hit;
    logic [1:0]         bim_value;
  } entry_t;

  entry_t             req_entry [REQ_NUM];
  entry_t             mem [QUEUE_DEPTH];
  entry_t             head_entry;
  logic [PTR_W-1:0]   head_reg, tail_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [RR_W-1:0]    rr_reg;
  logic [RR_W-1:0]    winner;
  logic [RR_W:0]      search_idx;
  logic               found;
  logic               not_full;
  logic               accept;
  logic               issue;
  logic [REQ_NUM-1:0] ready;

  for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_req
    assign req_entry[gi] = '{
      pc_vaddr:     bus.i_req_pc_vaddr[gi],
      target_vaddr: bus.i_req_target_vaddr[gi],
      is_cond:      bus.i_req_is_cond[gi],
      is_call:      bus.i_req_is_call[gi],
      is_ret:       bus.i_req_is_ret[gi],
      is_rvc:       bus.i_req_is_rvc[gi],
      taken:        bus.i_req_taken[gi],
      mispredict:   bus.i_req_mispredict[gi],
      btb_hit:      bus.i_req_btb_hit[gi],
      bim_value:    bus.i_req_bim_value[gi]
    };
  end

  // First valid requester at or above rr_reg, wrapping at REQ_NUM.
  always_comb begin
    winner     = '0;
    found      = 1'b0;
    search_idx = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      search_idx = {1'b0, rr_reg} + (RR_W+1)'(k);
      if (search_idx >= (RR_W+1)'(REQ_NUM)) begin
        search_idx = search_idx - (RR_W+1)'(REQ_NUM);
      end
      if (!found && bus.i_req_valid[search_idx[RR_W-1:0]]) begin
        found  = 1'b1;
        winner = search_idx[RR_W-1:0];
      end
    end
  end

  assign not_full = (count_reg != CNT_W'(QUEUE_DEPTH));
  assign accept   = i_reset_n && found && not_full;
  assign issue    = i_reset_n && (count_reg != '0) && !bus.i_upd_stall;

  always_comb begin
    ready = '0;
    if (accept) begin
      ready[winner] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      mem[tail_reg] <= req_entry[winner];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      rr_reg    <= '0;
    end else begin
      if (accept) begin
        tail_reg <= tail_reg + 1'b1;
        rr_reg   <= (winner == RR_W'(REQ_NUM - 1)) ? '0 : winner + 1'b1;
      end
      if (issue) begin
        head_reg <= head_reg + 1'b1;
      end
      case ({accept, issue})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_entry = mem[head_reg];

  assign bus.o_req_ready            = ready;
  assign bus.o_btb_upd_valid        = issue && (head_entry.taken || head_entry.mispredict ||
                                                head_entry.is_call || head_entry.is_ret);
  assign bus.o_btb_upd_is_cond      = head_entry.is_cond;
  assign bus.o_btb_upd_is_call      = head_entry.is_call;
  assign bus.o_btb_upd_is_ret       = head_entry.is_ret;
  assign bus.o_btb_upd_is_rvc       = head_entry.is_rvc;
  assign bus.o_btb_upd_taken        = head_entry.taken;
  assign bus.o_btb_upd_mispredict   = head_entry.mispredict;
  assign bus.o_btb_upd_pc_vaddr     = head_entry.pc_vaddr;
  assign bus.o_btb_upd_target_vaddr = head_entry.target_vaddr;

  assign bus.o_bim_upd_valid        = issue && head_entry.is_cond;
  assign bus.o_bim_upd_pc_vaddr     = head_entry.pc_vaddr;
  assign bus.o_bim_upd_hit          = head_entry.btb_hit;
  assign bus.o_bim_upd_taken        = head_entry.taken;
  assign bus.o_bim_upd_bim_value    = head_entry.bim_value;
  assign bus.o_bim_upd_is_rvc       = head_entry.is_rvc;

  assign bus.o_queue_count          = count_reg;
  assign bus.o_queue_full           = !not_full;
endmodule

// File: tb/tb_scariv_pred_update_sched.sv
// Directed plus randomized bench for scariv_pred_update_sched, checked against a
// queue-based model of the arbitration and drain rules.
module tb_scariv_pred_update_sched;
  localparam int REQ_NUM = 2;
  localparam int QD      = 4;
  localparam int VW      = 39;

  typedef struct {
    logic [VW-1:0] pc;
    logic [VW-1:0] tgt;
    logic c, call, ret, rvc, tk, mp, hit;
    logic [1:0] bim;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  scariv_pred_update_sched_if #(.REQ_NUM(REQ_NUM), .QUEUE_DEPTH(QD), .VADDR_W(VW)) bus ();

  scariv_pred_update_sched #(.REQ_NUM(REQ_NUM), .QUEUE_DEPTH(QD), .VADDR_W(VW)) dut (
    .i_clk    (clk),
    .i_reset_n(reset_n),
    .bus      (bus.master)
  );

  ent_t q[$];
  ent_t cur[REQ_NUM];
  int   rr;
  int   vectors;
  int   miscompares;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ent_t rand_ent();
    ent_t e;
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    e.pc = w[VW-1:0];
    w = {$urandom(), $urandom()};
    e.tgt = w[VW-1:0];
    {e.c, e.call, e.ret, e.rvc, e.tk, e.mp, e.hit} = 7'($urandom());
    e.bim = 2'($urandom());
    return e;
  endfunction

  function automatic ent_t mk_ent(logic [VW-1:0] pc, logic [VW-1:0] tgt,
                                  logic c, logic call, logic tk, logic [1:0] bim);
    ent_t e;
    e.pc = pc; e.tgt = tgt; e.c = c; e.call = call; e.ret = 1'b0;
    e.rvc = 1'b0; e.tk = tk; e.mp = 1'b0; e.hit = 1'b1; e.bim = bim;
    return e;
  endfunction

  task automatic set_req(int r, ent_t e);
    cur[r] = e;
    bus.i_req_pc_vaddr[r]     = e.pc;
    bus.i_req_target_vaddr[r] = e.tgt;
    bus.i_req_is_cond[r]      = e.c;
    bus.i_req_is_call[r]      = e.call;
    bus.i_req_is_ret[r]       = e.ret;
    bus.i_req_is_rvc[r]       = e.rvc;
    bus.i_req_taken[r]        = e.tk;
    bus.i_req_mispredict[r]   = e.mp;
    bus.i_req_btb_hit[r]      = e.hit;
    bus.i_req_bim_value[r]    = e.bim;
  endtask

  // Inputs are set at the negedge; check just after, then advance the model at posedge.
  task automatic cycle();
    int win;
    int idx;
    logic [REQ_NUM-1:0] exp_rdy;
    bit iss, exp_btb, exp_bim;
    ent_t h;
    #1;
    win = -1;
    for (int k = 0; k < REQ_NUM; k++) begin
      idx = (rr + k) % REQ_NUM;
      if (win < 0 && bus.i_req_valid[idx]) win = idx;
    end
    exp_rdy = '0;
    if (reset_n && win >= 0 && q.size() < QD) exp_rdy[win] = 1'b1;
    iss = reset_n && q.size() > 0 && !bus.i_upd_stall;
    exp_btb = 1'b0;
    exp_bim = 1'b0;
    if (iss) begin
      h = q[0];
      exp_btb = h.tk | h.mp | h.call | h.ret;
      exp_bim = h.c;
    end
    chk("ready", 64'(bus.o_req_ready), 64'(exp_rdy));
    if (reset_n) begin
      chk("count", 64'(bus.o_queue_count), 64'(q.size()));
      chk("full", 64'(bus.o_queue_full), 64'(q.size() == QD));
    end
    chk("btb_valid", 64'(bus.o_btb_upd_valid), 64'(exp_btb));
    chk("bim_valid", 64'(bus.o_bim_upd_valid), 64'(exp_bim));
    if (exp_btb) begin
      chk("btb_pc", 64'(bus.o_btb_upd_pc_vaddr), 64'(h.pc));
      chk("btb_target", 64'(bus.o_btb_upd_target_vaddr), 64'(h.tgt));
      chk("btb_flags",
          64'({bus.o_btb_upd_is_cond, bus.o_btb_upd_is_call, bus.o_btb_upd_is_ret,
               bus.o_btb_upd_is_rvc, bus.o_btb_upd_taken, bus.o_btb_upd_mispredict}),
          64'({h.c, h.call, h.ret, h.rvc, h.tk, h.mp}));
    end
    if (exp_bim) begin
      chk("bim_pc", 64'(bus.o_bim_upd_pc_vaddr), 64'(h.pc));
      chk("bim_fields",
          64'({bus.o_bim_upd_hit, bus.o_bim_upd_taken, bus.o_bim_upd_bim_value,
               bus.o_bim_upd_is_rvc}),
          64'({h.hit, h.tk, h.bim, h.rvc}));
    end
    @(posedge clk);
    if (!reset_n) begin
      q.delete();
      rr = 0;
    end else begin
      if (iss) void'(q.pop_front());
      if (exp_rdy != '0) begin
        q.push_back(cur[win]);
        rr = (win + 1) % REQ_NUM;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rr = 0;
    reset_n = 1'b0;
    bus.i_req_valid = '0;
    bus.i_upd_stall = 1'b0;
    for (int r = 0; r < REQ_NUM; r++) set_req(r, rand_ent());
    @(negedge clk);
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();

    // Single request with the reference values
    set_req(0, mk_ent(39'h1000, 39'h2000, 1'b1, 1'b0, 1'b1, 2'b01));
    bus.i_req_valid = 2'b01;
    cycle();
    bus.i_req_valid = 2'b00;
    cycle();
    cycle();

    // Round robin, both requesters always valid
    bus.i_req_valid = 2'b11;
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < REQ_NUM; r++) set_req(r, rand_ent());
      cycle();
    end
    bus.i_req_valid = 2'b00;
    cycle();
    cycle();

    // Fill under stall, then release
    bus.i_upd_stall = 1'b1;
    bus.i_req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < REQ_NUM; r++) set_req(r, rand_ent());
      cycle();
    end
    chk("full_after_stall", 64'(bus.o_queue_full), 64'd1);
    bus.i_upd_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < REQ_NUM; r++) set_req(r, rand_ent());
      cycle();
    end
    bus.i_req_valid = 2'b00;
    for (int i = 0; i < 6; i++) cycle();

    // Filtering: cond-only, call-only, no flags
    bus.i_req_valid = 2'b01;
    set_req(0, mk_ent(39'h3000, 39'h3100, 1'b1, 1'b0, 1'b0, 2'b10));
    cycle();
    set_req(0, mk_ent(39'h4000, 39'h4100, 1'b0, 1'b1, 1'b0, 2'b11));
    cycle();
    set_req(0, mk_ent(39'h5000, 39'h5100, 1'b0, 1'b0, 1'b0, 2'b00));
    cycle();
    bus.i_req_valid = 2'b00;
    cycle();
    cycle();

    // Wrap-around: 10 back-to-back accepts with continuous drain
    bus.i_req_valid = 2'b01;
    for (int i = 0; i < 10; i++) begin
      set_req(0, mk_ent(VW'(39'h100 * (i + 1)), VW'(39'h8000 + i), 1'b1, 1'b0, 1'b1, 2'(i)));
      cycle();
    end
    bus.i_req_valid = 2'b00;
    cycle();
    cycle();

    // Reset with three entries queued
    bus.i_upd_stall = 1'b1;
    bus.i_req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      set_req(1, rand_ent());
      cycle();
    end
    bus.i_req_valid = 2'b00;
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    bus.i_upd_stall = 1'b0;
    bus.i_req_valid = 2'b11;
    #1;
    chk("rst_count", 64'(bus.o_queue_count), 64'd0);
    chk("rst_rr_tie", 64'(bus.o_req_ready), 64'd1);
    cycle();
    bus.i_req_valid = 2'b00;
    cycle();
    cycle();

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      bus.i_req_valid = 2'($urandom_range(0, 3));
      bus.i_upd_stall = ($urandom_range(0, 3) == 0);
      reset_n = ($urandom_range(0, 80) != 0);
      for (int r = 0; r < REQ_NUM; r++) set_req(r, rand_ent());
      cycle();
    end
    reset_n = 1'b1;
    bus.i_req_valid = 2'b00;
    bus.i_upd_stall = 1'b0;
    for (int i = 0; i < 6; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
